// File: rtl/mini_alu_core_p_pkg.sv
// Shared definitions for the parametrised MiniAlu core: opcodes, MUL FSM states, decode helper.
package mini_alu_core_p_pkg;

    localparam int unsigned OP_NOP = 0;
    localparam int unsigned OP_LED = 1;
    localparam int unsigned OP_BLE = 2;
    localparam int unsigned OP_STO = 3;
    localparam int unsigned OP_ADD = 4;
    localparam int unsigned OP_JMP = 5;
    localparam int unsigned OP_SUB = 6;
    localparam int unsigned OP_MUL = 7;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mulState_e;

    // Any opcode above the last defined one is illegal.
    function automatic logic isIllegalOp(input logic [31:0] op);
        return op > 32'(OP_MUL);
    endfunction

endpackage

// File: rtl/rf_dual_read_p.sv
// Register file: two combinational read ports, one synchronous write port, no reset.
module rf_dual_read_p #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              Clock,
    input  logic              iWe,
    input  logic [ADDR_W-1:0] iWaddr,
    input  logic [DATA_W-1:0] iWdata,
    input  logic [ADDR_W-1:0] iRaddr1,
    output logic [DATA_W-1:0] oRdata1,
    input  logic [ADDR_W-1:0] iRaddr0,
    output logic [DATA_W-1:0] oRdata0
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge Clock) begin
        if (iWe) mem[iWaddr] <= iWdata;
    end

    assign oRdata1 = mem[iRaddr1];
    assign oRdata0 = mem[iRaddr0];

endmodule

// File: rtl/mini_alu_core_p.sv
// MiniAlu execution core: ROM fetch, decode registers, single-cycle execute, shift-add MUL with fetch stall.
module mini_alu_core_p
    import mini_alu_core_p_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned IP_W   = 16,
    parameter int unsigned LED_W  = 8
) (
    input  logic                       Clock,
    input  logic                       Reset,
    output logic [IP_W-1:0]            oIP,
    input  logic [OP_W+3*ADDR_W-1:0]   iInstruction,
    output logic [LED_W-1:0]           oLed,
    output logic                       oBusy,
    output logic                       oIllegalOp
);
    localparam int unsigned INSN_W = OP_W + 3 * ADDR_W;
    localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [IP_W-1:0]   pc;
    logic [OP_W-1:0]   decOp;
    logic [ADDR_W-1:0] decDest, decSrc1, decSrc0;
    logic [DATA_W-1:0] d1, d0;

    mulState_e         mulState;
    logic [DATA_W-1:0] mulMcand, mulMplier, mulAcc, mulStep;
    logic [CNT_W-1:0]  mulCnt;

    logic              branchTaken, stall, mulLast, rfWe;
    logic [DATA_W-1:0] rfWdata, immData;

    rf_dual_read_p #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) uRf (
        .Clock   (Clock),
        .iWe     (rfWe),
        .iWaddr  (decDest),
        .iWdata  (rfWdata),
        .iRaddr1 (decSrc1),
        .oRdata1 (d1),
        .iRaddr0 (decSrc0),
        .oRdata0 (d0)
    );

    assign immData = DATA_W'({decSrc1, decSrc0});
    assign mulLast = (mulState == MUL_RUN) && (mulCnt == '0);
    assign mulStep = mulAcc + (mulMplier[0] ? mulMcand : '0);

    // Execute decode: branch decision and register-file writeback.
    always_comb begin
        branchTaken = 1'b0;
        rfWe        = 1'b0;
        rfWdata     = '0;
        case (decOp)
            OP_W'(OP_BLE): branchTaken = (d1 <= d0);
            OP_W'(OP_JMP): branchTaken = 1'b1;
            OP_W'(OP_STO): begin rfWe = 1'b1; rfWdata = immData; end
            OP_W'(OP_ADD): begin rfWe = 1'b1; rfWdata = d1 + d0; end
            OP_W'(OP_SUB): begin rfWe = 1'b1; rfWdata = d1 - d0; end
            OP_W'(OP_MUL): begin rfWe = mulLast; rfWdata = mulStep; end
            default: ;
        endcase
    end

    // Fetch is held for the whole MUL except its final step, when the next instruction is latched.
    assign stall      = (decOp == OP_W'(OP_MUL)) && !mulLast;
    assign oIP        = branchTaken ? IP_W'(decDest) : pc;
    assign oBusy      = stall;
    assign oIllegalOp = isIllegalOp(32'(decOp));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc        <= '0;
            decOp     <= '0;
            decDest   <= '0;
            decSrc1   <= '0;
            decSrc0   <= '0;
            oLed      <= '0;
            mulState  <= MUL_IDLE;
            mulMcand  <= '0;
            mulMplier <= '0;
            mulAcc    <= '0;
            mulCnt    <= '0;
        end else begin
            if (!stall) begin
                pc      <= oIP + IP_W'(1);
                decOp   <= iInstruction[INSN_W-1 -: OP_W];
                decDest <= iInstruction[3*ADDR_W-1 -: ADDR_W];
                decSrc1 <= iInstruction[2*ADDR_W-1 -: ADDR_W];
                decSrc0 <= iInstruction[ADDR_W-1:0];
            end
            if (decOp == OP_W'(OP_LED)) oLed <= d1[LED_W-1:0];
            // LSB-first shift-add multiplier, one partial product per cycle.
            case (mulState)
                MUL_IDLE: begin
                    if (decOp == OP_W'(OP_MUL)) begin
                        mulMcand  <= d1;
                        mulMplier <= d0;
                        mulAcc    <= '0;
                        mulCnt    <= CNT_W'(DATA_W - 1);
                        mulState  <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    mulAcc    <= mulStep;
                    mulMcand  <= mulMcand << 1;
                    mulMplier <= mulMplier >> 1;
                    mulCnt    <= mulCnt - CNT_W'(1);
                    if (mulCnt == '0) mulState <= MUL_IDLE;
                end
                default: mulState <= MUL_IDLE;
            endcase
        end
    end

endmodule
